// File: rtl/cla_pipe_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor. One SEG-bit segment is
// resolved per stage. Operands are skewed in and partial sums deskewed out.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG;
    localparam int NG   = SEG / 4;

    // Returns {carry out of segment, segment sum}. Propagate is a|b, so the
    // sum uses the operand XOR rather than p.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] av,
                                             input logic [SEG-1:0] bv,
                                             input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] c;
        logic [NG-1:0]  gp;
        logic [NG-1:0]  gg;
        logic [NG:0]    gc;
        p = av | bv;
        g = av & bv;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                gp[j] = gp[j] & p[4*j+i];
            end
        end
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0) begin
                    c[4*j] = gc[j];
                end else begin
                    c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
                end
            end
        end
        return {gc[NG], av ^ bv ^ c};
    endfunction

    logic [WIDTH-1:0] bx;
    logic             ci0;
    logic             advance;

    assign bx       = sub ? ~b : b;
    assign ci0      = sub ? 1'b1 : cin;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : stg
            localparam int LO = gi * SEG;

            logic [SEG-1:0]    seg_a;
            logic [SEG-1:0]    seg_b;
            logic              seg_ci;
            logic              valid_in;
            logic [SEG:0]      seg_res;
            logic [LO+SEG-1:0] sum_next;
            logic              valid_reg;
            logic              carry_reg;
            logic [LO+SEG-1:0] sum_reg;

            if (gi == 0) begin : g_first
                assign seg_a    = a[SEG-1:0];
                assign seg_b    = bx[SEG-1:0];
                assign seg_ci   = ci0;
                assign valid_in = in_valid;
                assign sum_next = seg_res[SEG-1:0];
            end else begin : g_chain
                assign seg_a    = stg[gi-1].g_skew.a_reg[SEG-1:0];
                assign seg_b    = stg[gi-1].g_skew.b_reg[SEG-1:0];
                assign seg_ci   = stg[gi-1].carry_reg;
                assign valid_in = stg[gi-1].valid_reg;
                assign sum_next = {seg_res[SEG-1:0], stg[gi-1].sum_reg};
            end

            assign seg_res = seg_add(seg_a, seg_b, seg_ci);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= valid_in;
                    carry_reg <= seg_res[SEG];
                    sum_reg   <= sum_next;
                end
            end

            // Operand bits not yet consumed ride along behind the carry.
            if (gi < NSEG - 1) begin : g_skew
                localparam int HW = WIDTH - LO - SEG;
                logic [HW-1:0] a_reg;
                logic [HW-1:0] b_reg;
                logic [HW-1:0] a_next;
                logic [HW-1:0] b_next;

                if (gi == 0) begin : g_src
                    assign a_next = a[WIDTH-1:SEG];
                    assign b_next = bx[WIDTH-1:SEG];
                end else begin : g_fwd
                    assign a_next = stg[gi-1].g_skew.a_reg[HW+SEG-1:SEG];
                    assign b_next = stg[gi-1].g_skew.b_reg[HW+SEG-1:SEG];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (advance) begin
                        a_reg <= a_next;
                        b_reg <= b_next;
                    end
                end
            end

            if (gi == NSEG - 1) begin : g_last
                logic ovf_reg;
                logic zero_reg;

                // Carry into the MSB is recovered as a^b'^sum at that bit.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg  <= 1'b0;
                        zero_reg <= 1'b0;
                    end else if (advance) begin
                        ovf_reg  <= seg_res[SEG] ^ seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_res[SEG-1];
                        zero_reg <= ~|sum_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[NSEG-1].valid_reg;
    assign sum       = stg[NSEG-1].sum_reg;
    assign cout      = stg[NSEG-1].carry_reg;
    assign ovf       = stg[NSEG-1].g_last.ovf_reg;
    assign zero      = stg[NSEG-1].g_last.zero_reg;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three configurations fed from shared stimulus,
// each with its own expected-result queue filled on accept and drained on emit.
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        cin;
    logic        sub;

    logic        rdy0, vld0, cout0, ovf0, zero0;
    logic [15:0] sum0;
    logic        rdy1, vld1, cout1, ovf1, zero1;
    logic [31:0] sum1;
    logic        rdy2, vld2, cout2, ovf2, zero2;
    logic [15:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [34:0] q0[$];
    logic [34:0] q1[$];
    logic [34:0] q2[$];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(16), .SEG(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin), .sub(sub),
        .out_valid(vld0), .out_ready(out_ready),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0));

    cla_pipe_addsub #(.WIDTH(32), .SEG(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a_drv), .b(b_drv), .cin(cin), .sub(sub),
        .out_valid(vld1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));

    cla_pipe_addsub #(.WIDTH(16), .SEG(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin), .sub(sub),
        .out_valid(vld2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2));

    // Packed result: {ovf, zero, cout, sum[31:0]}.
    function automatic logic [34:0] model(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic c,
                                          input logic s);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        logic [32:0] full;
        logic [31:0] sm;
        logic        co;
        logic        ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = av & mask;
        bm   = (s ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'b0, (s ? 1'b1 : c)};
        sm   = full[31:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, (sm == 32'h0), co, sm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboards: accept/emit decided on the falling edge, before the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld0 && out_ready) begin
                if (q0.size() == 0) check("d0_spurious", 64'(q0.size()), 64'd1);
                else check("d0_result", 64'({ovf0, zero0, cout0, 16'h0, sum0}), 64'(q0.pop_front()));
            end
            if (in_valid && rdy0) q0.push_back(model(16, a_drv, b_drv, cin, sub));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vld1 && out_ready) begin
                if (q1.size() == 0) check("d1_spurious", 64'(q1.size()), 64'd1);
                else check("d1_result", 64'({ovf1, zero1, cout1, sum1}), 64'(q1.pop_front()));
            end
            if (in_valid && rdy1) q1.push_back(model(32, a_drv, b_drv, cin, sub));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vld2 && out_ready) begin
                if (q2.size() == 0) check("d2_spurious", 64'(q2.size()), 64'd1);
                else check("d2_result", 64'({ovf2, zero2, cout2, 16'h0, sum2}), 64'(q2.pop_front()));
            end
            if (in_valid && rdy2) q2.push_back(model(16, a_drv, b_drv, cin, sub));
        end
    end

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic s);
        bit done;
        done     = 1'b0;
        a_drv    = av;
        b_drv    = bv;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (rdy0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("drive_accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (q0.size() + q1.size() + q2.size()) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("drain_q2", 64'(q2.size()), 64'd0);
    endtask

    // Called right after the accepting edge T with an empty pipeline.
    task automatic latency_check();
        check("lat_d0_T", 64'(vld0), 64'd0);
        check("lat_d2_T", 64'(vld2), 64'd1);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            check("lat_d0_early", 64'(vld0), 64'd0);
        end
        @(posedge clk);
        #1;
        check("lat_d0_T3", 64'(vld0), 64'd1);
        check("lat_d1_T3", 64'(vld1), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [36:0] snap;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_drv     = 32'h0;
        b_drv     = 32'h0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_d0", 64'({vld0, sum0, cout0, ovf0, zero0}), 64'd0);
        check("rst_d1", 64'({vld1, sum1, cout1, ovf1, zero1}), 64'd0);
        check("rst_d2", 64'({vld2, sum2, cout2, ovf2, zero2}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'({rdy0, rdy1, rdy2}), 64'h7);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Carry out and zero, with latency
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        latency_check();
        drain();

        // Subtraction with overflow / borrow, then full-ripple carry
        drive(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
        drive(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);
        drive(32'h0000_7FFF, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        // 20 back-to-back beats with a stall in the middle
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                out_ready = 1'b0;
                a_drv     = 32'hDEAD_BEEF;
                b_drv     = 32'h1234_5678;
                in_valid  = 1'b1;
                @(negedge clk);
                snap = {rdy0, vld0, ovf0, zero0, cout0, 16'h0, sum0};
                check("stall_valid", 64'(vld0), 64'd1);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("stall_ready", 64'(rdy0), 64'd0);
                    check("stall_hold", 64'({rdy0, vld0, ovf0, zero0, cout0, 16'h0, sum0}), 64'(snap));
                end
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            drive(32'(i) * 32'h1111_1111, 32'(i) * 32'h0101_0303 + 32'h7, 1'(i), 1'(i / 3));
        end
        drain();

        // Reset with beats in flight
        for (int i = 0; i < 6; i++) begin
            drive(32'(i) * 32'h0F0F_0F0F, 32'h0000_1234, 1'b1, 1'b0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'({vld0, vld1, vld2}), 64'd0);
        check("midrst_sum0", 64'(sum0), 64'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", 64'({vld0, vld1, vld2}), 64'd0);
        drive(32'h1234_ABCD, 32'h0000_4321, 1'b0, 1'b1);
        latency_check();
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            a_drv     = $urandom;
            b_drv     = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
